// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART calculator sequencer: opcode values, ASCII
// opcode aliases and the sequencer FSM encoding.
package uart_alu_pkg;

  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;

  // '&' (0x26) is deliberately absent: that code is already XOR.
  localparam logic [7:0] ASCII_ADD = 8'h2B;
  localparam logic [7:0] ASCII_SUB = 8'h2D;
  localparam logic [7:0] ASCII_OR  = 8'h7C;
  localparam logic [7:0] ASCII_XOR = 8'h5E;
  localparam logic [7:0] ASCII_SRL = 8'h3E;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_OP,
    ST_WAIT_B,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/uart_alu_if_alu.sv
// Combinational calculator ALU. Defining UART_ALU_ASCII_OP_EN makes the opcode
// decoder also accept the ASCII operator aliases.
module alu
  import uart_alu_pkg::*;
#(
  parameter int NB_BITS = 8,
  parameter int NB_OP   = 8
) (
  input  logic [NB_BITS-1:0] a,
  input  logic [NB_BITS-1:0] b,
  input  logic [NB_OP-1:0]   op,
  output logic [NB_BITS-1:0] result
);

  logic [NB_OP-1:0] op_canon;
  logic [31:0]      shamt;
  logic             shift_oor;

  assign shamt     = 32'(b);
  assign shift_oor = (shamt >= 32'(NB_BITS));

`ifdef UART_ALU_ASCII_OP_EN
  always_comb begin
    op_canon = op;
    case (op)
      NB_OP'(ASCII_ADD): op_canon = NB_OP'(OP_ADD);
      NB_OP'(ASCII_SUB): op_canon = NB_OP'(OP_SUB);
      NB_OP'(ASCII_OR):  op_canon = NB_OP'(OP_OR);
      NB_OP'(ASCII_XOR): op_canon = NB_OP'(OP_XOR);
      NB_OP'(ASCII_SRL): op_canon = NB_OP'(OP_SRL);
      default:           op_canon = op;
    endcase
  end
`else
  assign op_canon = op;
`endif

  always_comb begin
    result = '0;
    case (op_canon)
      NB_OP'(OP_ADD): result = a + b;
      NB_OP'(OP_SUB): result = a - b;
      NB_OP'(OP_AND): result = a & b;
      NB_OP'(OP_OR):  result = a | b;
      NB_OP'(OP_XOR): result = a ^ b;
      NB_OP'(OP_NOR): result = ~(a | b);
      NB_OP'(OP_SRL): result = shift_oor ? '0 : (a >> b);
      // Oversized arithmetic shifts saturate to the sign fill.
      NB_OP'(OP_SRA): result = shift_oor ? {NB_BITS{a[NB_BITS-1]}}
                                         : $unsigned($signed(a) >>> b);
      default:        result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_if.sv
// Sequencer between UART rx and tx: collects A, opcode, B, evaluates them and
// hands the result to the transmitter. Optional macro: UART_ALU_ASCII_OP_EN.
module uart_alu_if
  import uart_alu_pkg::*;
#(
  parameter int NB_BITS = 8,
  parameter int NB_OP   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_BITS-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_drop
);

  state_t             state_reg, state_next;
  logic [NB_BITS-1:0] a_reg, a_next;
  logic [NB_OP-1:0]   op_reg, op_next;
  logic [NB_BITS-1:0] b_reg, b_next;
  logic [NB_BITS-1:0] result_reg, result_next;
  logic               busy_reg, busy_next;
  logic               drop_reg, drop_next;
  logic               tx_start;
  logic [NB_BITS-1:0] alu_result;

  alu #(
    .NB_BITS(NB_BITS),
    .NB_OP  (NB_OP)
  ) u_alu (
    .a     (a_reg),
    .b     (b_reg),
    .op    (op_reg),
    .result(alu_result)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg  <= ST_WAIT_A;
      a_reg      <= '0;
      op_reg     <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      op_reg     <= op_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
      drop_reg   <= drop_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    op_next     = op_reg;
    b_next      = b_reg;
    result_next = result_reg;
    drop_next   = 1'b0;
    tx_start    = 1'b0;
    case (state_reg)
      ST_WAIT_A: if (i_rx_done) begin
        a_next     = i_rx_data;
        state_next = ST_WAIT_OP;
      end
      ST_WAIT_OP: if (i_rx_done) begin
        op_next    = NB_OP'(i_rx_data);
        state_next = ST_WAIT_B;
      end
      ST_WAIT_B: if (i_rx_done) begin
        b_next     = i_rx_data;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        result_next = alu_result;
        drop_next   = i_rx_done;
        state_next  = ST_SEND;
      end
      ST_SEND: begin
        tx_start   = 1'b1;
        drop_next  = i_rx_done;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          // A byte arriving with tx_done starts the next operation directly.
          state_next = ST_WAIT_A;
          if (i_rx_done) begin
            a_next     = i_rx_data;
            state_next = ST_WAIT_OP;
          end
        end else begin
          drop_next = i_rx_done;
        end
      end
      default: state_next = ST_WAIT_A;
    endcase
    busy_next = (state_next == ST_EXEC) || (state_next == ST_SEND) ||
                (state_next == ST_WAIT_TX);
  end

  assign o_tx_data  = result_reg;
  assign o_tx_start = tx_start;
  assign o_busy     = busy_reg;
  assign o_drop     = drop_reg;

endmodule

// File: tb/tb_uart_alu_if.sv
// Randomised self-checking bench for uart_alu_if against an arithmetic
// reference model; honours UART_ALU_ASCII_OP_EN like the design.
module tb_uart_alu_if;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_drop;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] obs_data;
  int         obs_lat;
  int         obs_starts;
  logic       obs_busy_exec;
  bit         obs_hold_ok;

  uart_alu_if #(.NB_BITS(8), .NB_OP(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_done (i_rx_done),
    .i_tx_done (i_tx_done),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .o_busy    (o_busy),
    .o_drop    (o_drop)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ALU from the opcode table, using integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] op,
                                         input logic [7:0] b);
    int ai, bi, oc, sa, d, q;
    ai = a; bi = b; oc = op;
`ifdef UART_ALU_ASCII_OP_EN
    if (oc == 'h2B) oc = 'h20;
    if (oc == 'h2D) oc = 'h22;
    if (oc == 'h7C) oc = 'h25;
    if (oc == 'h5E) oc = 'h26;
    if (oc == 'h3E) oc = 'h02;
`endif
    case (oc)
      'h20: return 8'((ai + bi) % 256);
      'h22: return 8'((ai - bi + 256) % 256);
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return ~(a | b);
      'h02: return (bi >= 8) ? 8'h00 : 8'(ai / (1 << bi));
      'h03: begin
        sa = (ai >= 128) ? ai - 256 : ai;
        d  = 1 << ((bi >= 8) ? 8 : bi);
        q  = sa / d;
        if (sa < 0 && q * d != sa) q = q - 1;
        return 8'(q);
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    i_rx_data = d;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  // Sends the operands, then watches six cycles starting the cycle after B.
  task automatic do_op(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b,
                       input int gap, input bit send_a);
    if (send_a) begin
      send_byte(a);
      repeat (gap) step();
    end
    send_byte(op);
    repeat (gap) step();
    send_byte(b);
    obs_lat = -1; obs_starts = 0; obs_busy_exec = o_busy; obs_hold_ok = 1'b1;
    obs_data = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      if (o_tx_start === 1'b1) begin
        obs_starts++;
        if (obs_lat < 0) begin
          obs_lat  = c;
          obs_data = o_tx_data;
        end
      end else if (obs_lat > 0 && o_tx_data !== obs_data) begin
        obs_hold_ok = 1'b0;
      end
      if (c < 6) step();
    end
  endtask

  task automatic finish_tx();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0; i_rx_data = 8'h00;
    repeat (3) step();
    i_rst = 1'b1;
    n_cmp++; if (o_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h need 00", o_tx_data); end
    n_cmp++; if (o_tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b need 0", o_tx_start); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", o_busy); end
    n_cmp++; if (o_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b need 0", o_drop); end
    step();
  endtask

  task automatic test_basic();
    do_op(8'h53, 8'h20, 8'h01, 0, 1'b1);
    n_cmp++; if (obs_busy_exec !== 1'b1) begin n_bad++; $display("FAIL basic_busy_exec: got %b need 1", obs_busy_exec); end
    n_cmp++; if (obs_lat != 2) begin n_bad++; $display("FAIL basic_latency: got %0d need 2", obs_lat); end
    n_cmp++; if (obs_starts != 1) begin n_bad++; $display("FAIL basic_start_count: got %0d need 1", obs_starts); end
    n_cmp++; if (obs_data !== 8'h54) begin n_bad++; $display("FAIL basic_data: got %h need 54", obs_data); end
    n_cmp++; if (!obs_hold_ok) begin n_bad++; $display("FAIL basic_hold: tx_data changed in WAIT_TX, need stable 54"); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_wait: got %b need 1", o_busy); end
    finish_tx();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b need 0", o_busy); end
  endtask

  task automatic test_ascii();
    logic [7:0] exp;
`ifdef UART_ALU_ASCII_OP_EN
    exp = 8'h54;
`else
    exp = 8'h00;
`endif
    do_op(8'h53, 8'h2B, 8'h01, 1, 1'b1);
    n_cmp++; if (obs_data !== exp || obs_starts != 1) begin n_bad++; $display("FAIL ascii_plus: got %h starts %0d need %h starts 1", obs_data, obs_starts, exp); end
    finish_tx();
  endtask

  task automatic test_vectors();
    logic [31:0] tv [11] = '{32'hFF_20_01_00, 32'h00_22_01_FF, 32'h80_03_03_F0,
                             32'h80_02_09_00, 32'h80_03_09_FF, 32'h80_03_08_FF,
                             32'h80_02_07_01, 32'hF0_24_3C_30, 32'hF0_25_3C_FC,
                             32'hF0_26_3C_CC, 32'hF0_27_3C_03};
    logic [31:0] v;
    for (int i = 0; i < 11; i++) begin
      v = tv[i];
      do_op(v[31:24], v[23:16], v[15:8], i % 3, 1'b1);
      n_cmp++; if (obs_data !== v[7:0]) begin n_bad++; $display("FAIL vector_%0d: %h op %h %h got %h need %h", i, v[31:24], v[23:16], v[15:8], obs_data, v[7:0]); end
      finish_tx();
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [16] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03,
                             8'h2B, 8'h2D, 8'h7C, 8'h5E, 8'h3E, 8'h99, 8'h00, 8'hFF};
    logic [7:0] a, op, b, exp;
    for (int i = 0; i < 40; i++) begin
      a  = 8'($urandom);
      op = (i % 8 == 7) ? 8'($urandom) : ops[$urandom_range(0, 15)];
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      exp = ref_alu(a, op, b);
      do_op(a, op, b, $urandom_range(0, 3), 1'b1);
      n_cmp++; if (obs_data !== exp || obs_lat != 2 || obs_starts != 1) begin n_bad++; $display("FAIL random_%0d: %h op %h %h got %h lat %0d starts %0d need %h lat 2 starts 1", i, a, op, b, obs_data, obs_lat, obs_starts, exp); end
      repeat ($urandom_range(0, 2)) step();
      finish_tx();
    end
  endtask

  task automatic test_drop();
    send_byte(8'h0F); send_byte(8'h20); send_byte(8'h01);
    i_rx_done = 1'b1; i_rx_data = 8'hA5;
    step();
    n_cmp++; if (o_drop !== 1'b1 || o_tx_start !== 1'b1) begin n_bad++; $display("FAIL drop_exec: drop %b start %b need 1 1", o_drop, o_tx_start); end
    step();
    n_cmp++; if (o_drop !== 1'b1 || o_tx_start !== 1'b0) begin n_bad++; $display("FAIL drop_send: drop %b start %b need 1 0", o_drop, o_tx_start); end
    i_rx_done = 1'b0;
    step();
    n_cmp++; if (o_drop !== 1'b0) begin n_bad++; $display("FAIL drop_clear: got %b need 0", o_drop); end
    i_rx_done = 1'b1; i_rx_data = 8'h5A;
    step();
    i_rx_done = 1'b0;
    n_cmp++; if (o_drop !== 1'b1 || o_busy !== 1'b1) begin n_bad++; $display("FAIL drop_wait_tx: drop %b busy %b need 1 1", o_drop, o_busy); end
    step();
    n_cmp++; if (o_drop !== 1'b0 || o_tx_data !== 8'h10 || o_tx_start !== 1'b0) begin n_bad++; $display("FAIL drop_hold: drop %b data %h start %b need 0 10 0", o_drop, o_tx_data, o_tx_start); end
    i_rx_data = 8'h10; i_rx_done = 1'b1; i_tx_done = 1'b1;
    step();
    i_rx_done = 1'b0; i_tx_done = 1'b0;
    n_cmp++; if (o_drop !== 1'b0 || o_busy !== 1'b0) begin n_bad++; $display("FAIL coincident_flags: drop %b busy %b need 0 0", o_drop, o_busy); end
    do_op(8'h00, 8'h24, 8'h30, 0, 1'b0);
    n_cmp++; if (obs_data !== 8'h10 || obs_starts != 1) begin n_bad++; $display("FAIL coincident_result: got %h starts %0d need 10 starts 1", obs_data, obs_starts); end
    finish_tx();
  endtask

  task automatic test_tx_done_ignored();
    finish_tx();
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL txdone_idle_busy: got %b need 0", o_busy); end
    send_byte(8'h05);
    finish_tx();
    do_op(8'h00, 8'h22, 8'h03, 0, 1'b0);
    n_cmp++; if (obs_data !== 8'h02 || obs_lat != 2) begin n_bad++; $display("FAIL txdone_ignored: got %h lat %0d need 02 lat 2", obs_data, obs_lat); end
    finish_tx();
  endtask

  task automatic test_reset_mid();
    int starts;
    send_byte(8'h11); send_byte(8'h20);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    n_cmp++; if (o_tx_data !== 8'h00 || o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_drop !== 1'b0) begin n_bad++; $display("FAIL reset_mid_outputs: data %h busy %b start %b drop %b need 00 0 0 0", o_tx_data, o_busy, o_tx_start, o_drop); end
    do_op(8'h07, 8'h20, 8'h08, 1, 1'b1);
    n_cmp++; if (obs_data !== 8'h0F || obs_lat != 2 || obs_starts != 1) begin n_bad++; $display("FAIL reset_mid_fresh: got %h lat %0d starts %0d need 0F lat 2 starts 1", obs_data, obs_lat, obs_starts); end
    finish_tx();
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h01);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    starts = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_tx_start === 1'b1) starts++;
      step();
    end
    n_cmp++; if (starts != 0 || o_busy !== 1'b0 || o_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_exec_abort: starts %0d busy %b data %h need 0 0 00", starts, o_busy, o_tx_data); end
  endtask

  task automatic test_unknown();
    do_op(8'h12, 8'h99, 8'h34, 0, 1'b1);
    n_cmp++; if (obs_data !== 8'h00 || obs_starts != 1) begin n_bad++; $display("FAIL unknown_op: got %h starts %0d need 00 starts 1", obs_data, obs_starts); end
    finish_tx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, exp;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp = ref_alu(a, 8'h22, b);
      do_op(a, 8'h22, b, 0, 1'b1);
      n_cmp++; if (obs_data !== exp || obs_lat != 2) begin n_bad++; $display("FAIL back_to_back_%0d: %h - %h got %h lat %0d need %h lat 2", i, a, b, obs_data, obs_lat, exp); end
      finish_tx();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ascii();
    test_vectors();
    test_random();
    test_drop();
    test_tx_done_ignored();
    test_reset_mid();
    test_unknown();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
